// File: rtl/fcpu_rob_if.sv
// +--------------------------------------------------------------------------+
// | fcpu_rob_if : dispatch / CDB / lookup / commit bundle of the fcpu ROB    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fcpu_rob_if #(
  parameter int N_ROB_W    = 4,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  dispatch_valid;
  logic                  dispatch_ready;
  logic [2:0]            dispatch_type;
  logic [REG_ADDR_W-1:0] dispatch_dst_reg;
  logic [N_ROB_W-1:0]    dispatch_tag;
  logic                  cdb_valid;
  logic [N_ROB_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]     cdb_data;
  logic                  cdb_mispredict;
  logic [N_ROB_W-1:0]    src_tag;
  logic                  src_ready;
  logic [DATA_W-1:0]     src_data;
  logic                  commit_valid;
  logic                  commit_ready;
  logic [2:0]            commit_type;
  logic [REG_ADDR_W-1:0] commit_dst_reg;
  logic [DATA_W-1:0]     commit_data;
  logic [N_ROB_W-1:0]    commit_tag;
  logic                  flush;
  logic [N_ROB_W:0]      count;

  modport master (
    output dispatch_valid, dispatch_type, dispatch_dst_reg,
    output cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
    output src_tag, commit_ready,
    input  dispatch_ready, dispatch_tag, src_ready, src_data,
    input  commit_valid, commit_type, commit_dst_reg, commit_data, commit_tag,
    input  flush, count
  );

  modport slave (
    input  dispatch_valid, dispatch_type, dispatch_dst_reg,
    input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
    input  src_tag, commit_ready,
    output dispatch_ready, dispatch_tag, src_ready, src_data,
    output commit_valid, commit_type, commit_dst_reg, commit_data, commit_tag,
    output flush, count
  );
endinterface

`default_nettype wire

// File: rtl/fcpu_rob.sv
// +--------------------------------------------------------------------------+
// | fcpu_rob : reorder buffer, in-order alloc/retire, out-of-order complete  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fcpu_rob #(
  parameter int N_ROB_W    = 4,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rstn,
  fcpu_rob_if.slave  bus
);
  localparam int         C_DEPTH         = 1 << N_ROB_W;
  localparam logic [2:0] C_COMMIT_BRANCH = 3'd4;
  localparam logic [N_ROB_W:0] C_PTR_ONE = (N_ROB_W+1)'(1);

  logic [N_ROB_W:0]      head_q, head_d, tail_q, tail_d;
  logic [C_DEPTH-1:0]    busy_q, busy_d, done_q, done_d, mis_q, mis_d;
  logic                  flush_q, flush_d;
  logic [2:0]            type_q [C_DEPTH];
  logic [REG_ADDR_W-1:0] dst_q  [C_DEPTH];
  logic [DATA_W-1:0]     data_q [C_DEPTH];

  logic [N_ROB_W-1:0] head_idx, tail_idx;
  logic full, disp_rdy, disp_fire, cmt_vld, cmt_fire, mis_flush, cdb_fire;

  assign head_idx  = head_q[N_ROB_W-1:0];
  assign tail_idx  = tail_q[N_ROB_W-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[N_ROB_W] != tail_q[N_ROB_W]);
  assign disp_rdy  = rstn & ~full & ~flush_q;
  assign disp_fire = bus.dispatch_valid & disp_rdy;
  assign cmt_vld   = rstn & ~flush_q & busy_q[head_idx] & done_q[head_idx];
  assign cmt_fire  = cmt_vld & bus.commit_ready;
  assign mis_flush = cmt_fire & mis_q[head_idx] & (type_q[head_idx] == C_COMMIT_BRANCH);
  // A result racing the allocation of its own slot, or a flushing retire, is dropped.
  assign cdb_fire  = bus.cdb_valid & busy_q[bus.cdb_tag] & ~flush_q & ~mis_flush
                   & ~(disp_fire & (bus.cdb_tag == tail_idx));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mis_d   = mis_q;
    flush_d = 1'b0;
    if (cdb_fire) begin
      done_d[bus.cdb_tag] = 1'b1;
      mis_d[bus.cdb_tag]  = bus.cdb_mispredict;
    end
    if (cmt_fire) begin
      busy_d[head_idx] = 1'b0;
      done_d[head_idx] = 1'b0;
      head_d           = head_q + C_PTR_ONE;
    end
    if (disp_fire) begin
      busy_d[tail_idx] = 1'b1;
      done_d[tail_idx] = 1'b0;
      mis_d[tail_idx]  = 1'b0;
      tail_d           = tail_q + C_PTR_ONE;
    end
    // Retiring a mispredicted branch empties the buffer behind the new head.
    if (mis_flush) begin
      busy_d  = '0;
      done_d  = '0;
      mis_d   = '0;
      tail_d  = head_q + C_PTR_ONE;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      mis_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    if (disp_fire) begin
      type_q[tail_idx] <= bus.dispatch_type;
      dst_q[tail_idx]  <= bus.dispatch_dst_reg;
    end
    if (cdb_fire) begin
      data_q[bus.cdb_tag] <= bus.cdb_data;
    end
  end

  assign bus.dispatch_ready = disp_rdy;
  assign bus.dispatch_tag   = tail_idx;
  assign bus.src_ready      = busy_q[bus.src_tag] & done_q[bus.src_tag];
  assign bus.src_data       = data_q[bus.src_tag];
  assign bus.commit_valid   = cmt_vld;
  assign bus.commit_type    = type_q[head_idx];
  assign bus.commit_dst_reg = dst_q[head_idx];
  assign bus.commit_data    = data_q[head_idx];
  assign bus.commit_tag     = head_idx;
  assign bus.flush          = flush_q;
  assign bus.count          = tail_q - head_q;
endmodule

`default_nettype wire

// File: tb/tb_fcpu_rob.sv
// +--------------------------------------------------------------------------+
// | tb_fcpu_rob : directed scoreboard bench for the fcpu reorder buffer      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fcpu_rob;
  localparam int N_ROB_W    = 4;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fcpu_rob_if #(.N_ROB_W(N_ROB_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  fcpu_rob #(.N_ROB_W(N_ROB_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [2:0]  typ;
    logic [4:0]  dst;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_tail;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Scores any retire happening at the coming edge, then advances one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.commit_valid === 1'b1 && bus.commit_ready === 1'b1) begin
      check("commit_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("commit_tag",  64'(bus.commit_tag),     64'(e.tag));
        check("commit_type", 64'(bus.commit_type),    64'(e.typ));
        check("commit_dst",  64'(bus.commit_dst_reg), 64'(e.dst));
        check("commit_data", 64'(bus.commit_data),    64'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [2:0] typ, input logic [4:0] dst,
                          input logic [31:0] data, input bit expect_commit);
    exp_t e;
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_type    = typ;
    bus.dispatch_dst_reg = dst;
    #1;
    check("dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
    check("dispatch_tag",   64'(bus.dispatch_tag),   64'(exp_tail));
    if (expect_commit) begin
      e.tag = exp_tail; e.typ = typ; e.dst = dst; e.data = data;
      sb.push_back(e);
    end
    tick();
    bus.dispatch_valid = 1'b0;
    exp_tail++;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data, input logic mis);
    bus.cdb_valid      = 1'b1;
    bus.cdb_tag        = tag;
    bus.cdb_data       = data;
    bus.cdb_mispredict = mis;
    tick();
    bus.cdb_valid      = 1'b0;
    bus.cdb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rstn                 = 1'b0;
    bus.dispatch_valid   = 1'b0;
    bus.dispatch_type    = 3'd0;
    bus.dispatch_dst_reg = '0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_tag          = '0;
    bus.cdb_data         = '0;
    bus.cdb_mispredict   = 1'b0;
    bus.src_tag          = '0;
    bus.commit_ready     = 1'b0;
    tick();
    check("rst_dispatch_ready", 64'(bus.dispatch_ready), 64'd0);
    check("rst_commit_valid",   64'(bus.commit_valid),   64'd0);
    check("rst_count",          64'(bus.count),          64'd0);
    check("rst_flush",          64'(bus.flush),          64'd0);
    rstn = 1'b1;
    sb.delete();
    exp_tail = 4'd0;
  endtask

  initial begin
    logic [3:0] t;

    // 1: fill all sixteen slots back to back
    do_reset();
    for (int i = 0; i < 16; i++) dispatch(3'd0, 5'(i), 32'd0, 1'b0);
    check("fill_count", 64'(bus.count), 64'd16);
    check("fill_ready", 64'(bus.dispatch_ready), 64'd0);
    bus.dispatch_valid = 1'b1;
    tick();
    bus.dispatch_valid = 1'b0;
    check("full_blocks", 64'(bus.count), 64'd16);

    // 2: out-of-order completion, in-order retire
    do_reset();
    bus.commit_ready = 1'b1;
    dispatch(3'd0, 5'd1, 32'hA, 1'b1);
    dispatch(3'd0, 5'd2, 32'hB, 1'b1);
    dispatch(3'd0, 5'd3, 32'hC, 1'b1);
    cdb(4'd2, 32'hC, 1'b0);
    check("ooo_head_wait", 64'(bus.commit_valid), 64'd0);
    bus.src_tag = 4'd2;
    #1;
    check("src2_ready", 64'(bus.src_ready), 64'd1);
    check("src2_data",  64'(bus.src_data),  64'hC);
    bus.src_tag = 4'd0;
    #1;
    check("src0_notready", 64'(bus.src_ready), 64'd0);
    cdb(4'd0, 32'hA, 1'b0);
    check("t0_commit_valid", 64'(bus.commit_valid), 64'd1);
    cdb(4'd1, 32'hB, 1'b0);
    check("t1_commit_valid", 64'(bus.commit_valid), 64'd1);
    tick();
    check("t2_commit_valid", 64'(bus.commit_valid), 64'd1);
    tick();
    check("ooo_count", 64'(bus.count), 64'd0);
    check("ooo_sb_drained", 64'(sb.size()), 64'd0);

    // 3: mispredicted branch flushes younger work
    do_reset();
    dispatch(3'd0, 5'd4, 32'h10, 1'b1);
    dispatch(3'd4, 5'd0, 32'h11, 1'b1);
    dispatch(3'd0, 5'd5, 32'h12, 1'b0);
    cdb(4'd1, 32'h11, 1'b1);
    cdb(4'd0, 32'h10, 1'b0);
    cdb(4'd2, 32'h12, 1'b0);
    check("br_head_valid", 64'(bus.commit_valid), 64'd1);
    bus.commit_ready = 1'b1;
    tick();
    check("br_preflush", 64'(bus.flush), 64'd0);
    check("br_head_tag",  64'(bus.commit_tag), 64'd1);
    bus.dispatch_valid = 1'b1;
    tick();
    bus.dispatch_valid = 1'b0;
    check("flush_pulse",      64'(bus.flush),          64'd1);
    check("flush_count",      64'(bus.count),          64'd0);
    check("flush_no_commit",  64'(bus.commit_valid),   64'd0);
    check("flush_no_ready",   64'(bus.dispatch_ready), 64'd0);
    bus.src_tag = 4'd2;
    tick();
    check("flush_cleared",    64'(bus.flush),        64'd0);
    check("post_flush_count", 64'(bus.count),        64'd0);
    check("t2_never_commits", 64'(bus.commit_valid), 64'd0);
    check("t2_src_cleared",   64'(bus.src_ready),    64'd0);
    exp_tail = 4'd2;
    dispatch(3'd0, 5'd6, 32'h13, 1'b1);
    cdb(4'd2, 32'h13, 1'b0);
    tick();
    check("post_flush_drain", 64'(bus.count), 64'd0);

    // 4: pointer wrap under steady traffic
    do_reset();
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      t = exp_tail;
      dispatch(3'd0, 5'(i), 32'(i * 3 + 1), 1'b1);
      check("wrap_count1", 64'(bus.count), 64'd1);
      check("wrap_ready",  64'(bus.dispatch_ready), 64'd1);
      cdb(t, 32'(i * 3 + 1), 1'b0);
      check("wrap_cvalid", 64'(bus.commit_valid), 64'd1);
      tick();
      check("wrap_count0", 64'(bus.count), 64'd0);
    end

    // 5: stray CDB to an idle slot, and no same-cycle bypass
    do_reset();
    cdb(4'd7, 32'hDEAD, 1'b0);
    check("stray_count",  64'(bus.count),        64'd0);
    check("stray_commit", 64'(bus.commit_valid), 64'd0);
    bus.src_tag = 4'd7;
    #1;
    check("stray_src", 64'(bus.src_ready), 64'd0);
    for (int i = 0; i < 8; i++) dispatch(3'd0, 5'(i), 32'd0, 1'b0);
    check("slot7_not_done", 64'(bus.src_ready), 64'd0);
    check("eight_count",    64'(bus.count),     64'd8);
    bus.src_tag   = 4'd6;
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 4'd6;
    bus.cdb_data  = 32'h66;
    #1;
    check("no_bypass", 64'(bus.src_ready), 64'd0);
    tick();
    bus.cdb_valid = 1'b0;
    check("src6_ready", 64'(bus.src_ready), 64'd1);
    check("src6_data",  64'(bus.src_data),  64'h66);

    // 6: reset mid-stream discards everything
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(3'd0, 5'(i), 32'd0, 1'b0);
    cdb(4'd0, 32'h55, 1'b0);
    check("pre_rst_count",  64'(bus.count),        64'd5);
    check("pre_rst_commit", 64'(bus.commit_valid), 64'd1);
    rstn             = 1'b0;
    bus.commit_ready = 1'b1;
    tick();
    check("mid_rst_count",  64'(bus.count),        64'd0);
    check("mid_rst_commit", 64'(bus.commit_valid), 64'd0);
    check("mid_rst_flush",  64'(bus.flush),        64'd0);
    rstn     = 1'b1;
    exp_tail = 4'd0;
    #1;
    check("post_rst_tag",    64'(bus.dispatch_tag),   64'd0);
    check("post_rst_ready",  64'(bus.dispatch_ready), 64'd1);
    check("post_rst_commit", 64'(bus.commit_valid),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
